// File: rtl/decode_stage.sv
// Decode stage: register file, operand read and one-entry output register.
// Optional macro DECODE_BYPASS_EN enables writeback-to-decode forwarding.
module decode_stage #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [31:0]     pc,
    input  logic            flush,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_id,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [31:0]     out_pc,
    output logic [AW-1:0]   out_rd_id,
    output logic [XLEN-1:0] out_rs1_val,
    output logic [XLEN-1:0] out_rs2_val
);

    localparam int NREG = 2 ** AW;

    logic [XLEN-1:0] rf_q [NREG];
    logic [XLEN-1:0] rf_d [NREG];

    logic            out_valid_q, out_valid_d;
    logic [31:0]     out_instr_q, out_instr_d;
    logic [31:0]     out_pc_q, out_pc_d;
    logic [AW-1:0]   out_rd_id_q, out_rd_id_d;
    logic [XLEN-1:0] out_rs1_val_q, out_rs1_val_d;
    logic [XLEN-1:0] out_rs2_val_q, out_rs2_val_d;

    logic [AW-1:0]   rs1_id, rs2_id, rd_id;
    logic [AW-1:0]   hrs1_id, hrs2_id;
    logic            wb_hit;
    logic            stall;
    logic            accept;
    logic [XLEN-1:0] rs1_val, rs2_val;

    assign rs1_id  = instr[15 +: AW];
    assign rs2_id  = instr[20 +: AW];
    assign rd_id   = instr[7 +: AW];
    assign hrs1_id = out_instr_q[15 +: AW];
    assign hrs2_id = out_instr_q[20 +: AW];

    // x0 is hardwired, so a writeback to it is never a real write
    assign wb_hit = wb_en && (wb_id != '0);

    // Operand read, with optional forwarding of the same-cycle writeback
    always_comb begin
        rs1_val = (rs1_id == '0) ? '0 : rf_q[rs1_id];
        rs2_val = (rs2_id == '0) ? '0 : rf_q[rs2_id];
`ifdef DECODE_BYPASS_EN
        if (wb_hit && (wb_id == rs1_id)) begin
            rs1_val = wb_data;
        end
        if (wb_hit && (wb_id == rs2_id)) begin
            rs2_val = wb_data;
        end
`endif
    end

    // Without forwarding, hold off an instruction whose source is being written
    always_comb begin
`ifdef DECODE_BYPASS_EN
        stall = 1'b0;
`else
        stall = in_valid && wb_hit &&
                ((wb_id == rs1_id) || (wb_id == rs2_id));
`endif
    end

    assign in_ready = !flush && !stall && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    // Register file next state; entry 0 is never written
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            rf_d[i] = rf_q[i];
        end
        if (wb_hit) begin
            rf_d[wb_id] = wb_data;
        end
        rf_d[0] = '0;
    end

    // Output register: flush, then accept, then drain, then hold
    always_comb begin
        out_valid_d   = out_valid_q;
        out_instr_d   = out_instr_q;
        out_pc_d      = out_pc_q;
        out_rd_id_d   = out_rd_id_q;
        out_rs1_val_d = out_rs1_val_q;
        out_rs2_val_d = out_rs2_val_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d   = 1'b1;
            out_instr_d   = instr;
            out_pc_d      = pc;
            out_rd_id_d   = rd_id;
            out_rs1_val_d = rs1_val;
            out_rs2_val_d = rs2_val;
        end else if (out_valid_q) begin
            if (out_ready) begin
                out_valid_d = 1'b0;
            end
            // keep held operands coherent with later writebacks
            if (wb_hit && (wb_id == hrs1_id)) begin
                out_rs1_val_d = wb_data;
            end
            if (wb_hit && (wb_id == hrs2_id)) begin
                out_rs2_val_d = wb_data;
            end
        end
    end

    // Register file storage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= rf_d[i];
            end
        end
    end

    // Output pipeline register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q   <= 1'b0;
            out_instr_q   <= '0;
            out_pc_q      <= '0;
            out_rd_id_q   <= '0;
            out_rs1_val_q <= '0;
            out_rs2_val_q <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            out_instr_q   <= out_instr_d;
            out_pc_q      <= out_pc_d;
            out_rd_id_q   <= out_rd_id_d;
            out_rs1_val_q <= out_rs1_val_d;
            out_rs2_val_q <= out_rs2_val_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_instr   = out_instr_q;
    assign out_pc      = out_pc_q;
    assign out_rd_id   = out_rd_id_q;
    assign out_rs1_val = out_rs1_val_q;
    assign out_rs2_val = out_rs2_val_q;

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: directed scenarios plus randomized traffic
// checked against a transaction-level reference model.
module tb_decode_stage;

`ifdef DECODE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        flush;
    logic        wb_en;
    logic [4:0]  wb_id;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [4:0]  out_rd_id;
    logic [31:0] out_rs1_val;
    logic [31:0] out_rs2_val;

    int checks = 0;
    int errors = 0;

    decode_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .pc(pc), .flush(flush),
        .wb_en(wb_en), .wb_id(wb_id), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc),
        .out_rd_id(out_rd_id),
        .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: architectural registers plus the held instruction
    logic [31:0] m_rf [32];
    logic        m_valid;
    logic [31:0] m_instr, m_pc, m_v1, m_v2;

    function automatic logic [31:0] mk(input int r1, input int r2,
                                       input int rd, input int f);
        logic [4:0] a, b, d;
        logic [2:0] f3;
        a = r1[4:0]; b = r2[4:0]; d = rd[4:0]; f3 = f[2:0];
        return {7'h00, b, a, f3, d, 7'h33};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
        m_valid = 1'b0;
        m_instr = 0; m_pc = 0; m_v1 = 0; m_v2 = 0;
    endtask

    task automatic chk_out();
        chk("out_valid", {63'h0, out_valid}, {63'h0, m_valid});
        if (m_valid) begin
            chk("out_instr", {32'h0, out_instr}, {32'h0, m_instr});
            chk("out_pc", {32'h0, out_pc}, {32'h0, m_pc});
            chk("out_rd_id", {59'h0, out_rd_id}, {59'h0, m_instr[11:7]});
            chk("out_rs1_val", {32'h0, out_rs1_val}, {32'h0, m_v1});
            chk("out_rs2_val", {32'h0, out_rs2_val}, {32'h0, m_v2});
        end
    endtask

    task automatic chk_zero();
        chk("rst_valid", {63'h0, out_valid}, 64'h0);
        chk("rst_instr", {32'h0, out_instr}, 64'h0);
        chk("rst_pc", {32'h0, out_pc}, 64'h0);
        chk("rst_rd", {59'h0, out_rd_id}, 64'h0);
        chk("rst_rs1", {32'h0, out_rs1_val}, 64'h0);
        chk("rst_rs2", {32'h0, out_rs2_val}, 64'h0);
    endtask

    // one clock cycle with the inputs currently driven
    task automatic step();
        logic [4:0]  r1, r2;
        logic        hit, stl, rdy, acc;
        logic [31:0] v1, v2;
        #1;
        r1  = instr[19:15];
        r2  = instr[24:20];
        hit = wb_en && (wb_id != 0);
        stl = !BYP && in_valid && hit && (wb_id == r1 || wb_id == r2);
        rdy = !flush && !stl && (!m_valid || out_ready);
        chk("in_ready", {63'h0, in_ready}, {63'h0, rdy});
        acc = in_valid && rdy;
        v1 = (r1 == 0) ? 32'h0 :
             (BYP && hit && wb_id == r1) ? wb_data : m_rf[r1];
        v2 = (r2 == 0) ? 32'h0 :
             (BYP && hit && wb_id == r2) ? wb_data : m_rf[r2];
        if (flush) begin
            m_valid = 1'b0;
        end else if (acc) begin
            m_valid = 1'b1;
            m_instr = instr; m_pc = pc; m_v1 = v1; m_v2 = v2;
        end else if (m_valid) begin
            if (out_ready) m_valid = 1'b0;
            if (hit && wb_id == m_instr[19:15]) m_v1 = wb_data;
            if (hit && wb_id == m_instr[24:20]) m_v2 = wb_data;
        end
        if (hit) m_rf[wb_id] = wb_data;
        @(posedge clk);
        #1;
        chk_out();
    endtask

    task automatic idle();
        in_valid = 0; flush = 0; wb_en = 0; wb_id = 0; wb_data = 0;
        out_ready = 1;
    endtask

    logic [31:0] seq [8];

    initial begin
        rst = 0;
        idle();
        instr = 0; pc = 0;
        model_reset();
        #3;
        chk_zero();
        #9;
        rst = 1;

        // x5 = 0x1234, then read rs1=5, rs2=0
        wb_en = 1; wb_id = 5; wb_data = 32'h1234;
        step();
        idle();
        in_valid = 1; instr = mk(5, 0, 9, 0); pc = 32'h100;
        step();
        chk("req24_rs1", {32'h0, out_rs1_val}, 64'h1234);
        chk("req24_rs2", {32'h0, out_rs2_val}, 64'h0);

        // rs1=rs2=3 while x3 is written in the same cycle
        instr = mk(3, 3, 4, 1); pc = 32'h104;
        wb_en = 1; wb_id = 3; wb_data = 32'hABCD;
        step();
        if (!BYP) begin
            wb_en = 0;
            step();
        end
        chk("req25_rs1", {32'h0, out_rs1_val}, 64'hABCD);
        chk("req25_rs2", {32'h0, out_rs2_val}, 64'hABCD);
        chk("req25_pc", {32'h0, out_pc}, 64'h104);

        // backpressure with rs2=7 held, then x7 written
        idle();
        in_valid = 1; instr = mk(1, 7, 2, 2); pc = 32'h108;
        step();
        in_valid = 0; out_ready = 0;
        wb_en = 1; wb_id = 7; wb_data = 32'h55;
        step();
        chk("req26_rs2", {32'h0, out_rs2_val}, 64'h55);
        chk("req26_pc", {32'h0, out_pc}, 64'h108);
        wb_en = 0; in_valid = 1; instr = mk(2, 2, 2, 3); pc = 32'h10C;
        step();

        // write to x0 must be ignored
        idle();
        wb_en = 1; wb_id = 0; wb_data = 32'hFFFF;
        step();
        idle();
        in_valid = 1; instr = mk(0, 5, 1, 4); pc = 32'h110;
        step();
        chk("req27_rs1", {32'h0, out_rs1_val}, 64'h0);

        // flush with an instruction held and another offered
        instr = mk(1, 2, 3, 5); pc = 32'h114; flush = 1;
        step();
        chk("req28_valid", {63'h0, out_valid}, 64'h0);
        flush = 0;
        step();
        chk("req28_pc", {32'h0, out_pc}, 64'h114);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            wb_en     = $urandom_range(0, 1) == 1;
            wb_id     = 5'($urandom_range(0, 7));
            wb_data   = $urandom;
            instr     = mk($urandom_range(0, 7), $urandom_range(0, 7),
                           $urandom_range(0, 31), $urandom_range(0, 7));
            pc        = $urandom;
            step();
        end

        // 8 back-to-back instructions, full throughput
        idle();
        step();
        for (int i = 0; i < 8; i++) begin
            seq[i] = mk(i + 1, i + 2, i + 3, i);
            in_valid = 1; instr = seq[i]; pc = 32'h200 + 4 * i;
            step();
            chk("stream_valid", {63'h0, out_valid}, 64'h1);
            chk("stream_order", {32'h0, out_instr}, {32'h0, seq[i]});
        end

        // reset mid-stream
        instr = mk(5, 3, 1, 0); pc = 32'h300;
        rst = 0;
        #1;
        chk_zero();
        model_reset();
        #2;
        rst = 1;
        step();
        chk("post_rst_valid", {63'h0, out_valid}, 64'h1);
        chk("post_rst_rf5", {32'h0, out_rs1_val}, 64'h0);
        chk("post_rst_rf3", {32'h0, out_rs2_val}, 64'h0);
        idle();
        step();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
